// File: rtl/alu_sched_pkg.sv
// rtl/alu_sched_pkg.sv - shared types, constants and latency select for the ALU op scheduler
// Contents: state_t (scheduler FSM), flags_t {err,oflow,cout,g,l,e},
//           MUL_INC/MUL_SHIFT command codes, CNT_W wait-counter width, lat_sel().
package alu_sched_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   typedef struct packed {
      logic err;
      logic oflow;
      logic cout;
      logic g;
      logic l;
      logic e;
   } flags_t;

   localparam int unsigned MUL_INC   = 9;
   localparam int unsigned MUL_SHIFT = 10;
   localparam int          CNT_W     = 8;

   // Multiplies are the only arithmetic ops with the longer pipeline.
   function automatic logic [CNT_W-1:0] lat_sel(input logic        mode,
                                                input int unsigned cmd,
                                                input int unsigned lat,
                                                input int unsigned mul_lat);
      if (mode && (cmd == MUL_INC || cmd == MUL_SHIFT))
         return CNT_W'(mul_lat);
      return CNT_W'(lat);
   endfunction

endpackage

// File: rtl/alu_op_scheduler_if.sv
// rtl/alu_op_scheduler_if.sv - requester/response bundle between the fabric and the scheduler
// master: requester fabric (drives req_*, rsp_ready; sees req_ready, rsp_*)
// slave:  scheduler        (drives req_ready, rsp_valid/id/res/flags)
interface alu_op_scheduler_if #(
   parameter int N_REQ = 4,
   parameter int N     = 8,
   parameter int M     = 4
);
   localparam int ID_W = $clog2(N_REQ);

   logic [N_REQ-1:0]   req_valid;
   logic [N_REQ-1:0]   req_ready;
   logic [N_REQ-1:0]   req_mode;
   logic [N_REQ*M-1:0] req_cmd;
   logic [N_REQ*N-1:0] req_opa;
   logic [N_REQ*N-1:0] req_opb;
   logic [N_REQ-1:0]   req_cin;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [ID_W-1:0]    rsp_id;
   logic [N+1:0]       rsp_res;
   logic [5:0]         rsp_flags;

   modport master (
      output req_valid, req_mode, req_cmd, req_opa, req_opb, req_cin, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_res, rsp_flags
   );

   modport slave (
      input  req_valid, req_mode, req_cmd, req_opa, req_opb, req_cin, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_res, rsp_flags
   );
endinterface

// File: rtl/alu_rr_arbiter.sv
// rtl/alu_rr_arbiter.sv - combinational round-robin arbiter
// Ports: req (request vector), last_grant (previous winner) in;
//        grant (one-hot), grant_id (encoded), any (some request present) out.
module alu_rr_arbiter #(
   parameter  int N_REQ = 4,
   localparam int ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  last_grant,
   output logic [N_REQ-1:0] grant,
   output logic [ID_W-1:0]  grant_id,
   output logic             any
);
   logic [ID_W-1:0] idx;

   // Search starts one past the previous winner so it ends up with lowest priority.
   always_comb begin
      grant    = '0;
      grant_id = '0;
      any      = 1'b0;
      idx      = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = ID_W'((int'(last_grant) + k) % N_REQ);
         if (!any && req[idx]) begin
            any         = 1'b1;
            grant[idx]  = 1'b1;
            grant_id    = idx;
         end
      end
   end
endmodule

// File: rtl/alu_op_scheduler.sv
// rtl/alu_op_scheduler.sv - round-robin sharing of one ALU between N_REQ requesters
// Ports: clk, reset (sync, active-high); bus (slave side of alu_op_scheduler_if);
//        alu_ce/alu_inp_valid/alu_mode/alu_cmd/alu_opa/alu_opb/alu_cin to the ALU;
//        alu_res and alu_err/oflow/cout/g/l/e from the ALU.
module alu_op_scheduler
   import alu_sched_pkg::*;
#(
   parameter  int N_REQ   = 4,
   parameter  int N       = 8,
   parameter  int M       = 4,
   parameter  int LAT     = 1,
   parameter  int MUL_LAT = 2,
   localparam int ID_W    = $clog2(N_REQ)
) (
   input  logic                clk,
   input  logic                reset,
   alu_op_scheduler_if.slave   bus,
   output logic                alu_ce,
   output logic [1:0]          alu_inp_valid,
   output logic                alu_mode,
   output logic [M-1:0]        alu_cmd,
   output logic [N-1:0]        alu_opa,
   output logic [N-1:0]        alu_opb,
   output logic                alu_cin,
   input  logic [N+1:0]        alu_res,
   input  logic                alu_err,
   input  logic                alu_oflow,
   input  logic                alu_cout,
   input  logic                alu_g,
   input  logic                alu_l,
   input  logic                alu_e
);
   state_t           state, state_next;
   logic [N_REQ-1:0] grant, req_ready_c;
   logic [ID_W-1:0]  grant_id, last_grant;
   logic             any_req, take;

   logic             op_mode, op_cin;
   logic [M-1:0]     op_cmd;
   logic [N-1:0]     op_opa, op_opb;
   logic [ID_W-1:0]  op_id;
   logic [CNT_W-1:0] cnt;
   logic [N+1:0]     res_q;
   flags_t           flags_q;

   logic             sel_mode, sel_cin;
   logic [M-1:0]     sel_cmd;
   logic [N-1:0]     sel_opa, sel_opb;

   alu_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .req        (bus.req_valid),
      .last_grant (last_grant),
      .grant      (grant),
      .grant_id   (grant_id),
      .any        (any_req)
   );

   // Operand mux for the granted requester.
   always_comb begin
      sel_mode = 1'b0;
      sel_cin  = 1'b0;
      sel_cmd  = '0;
      sel_opa  = '0;
      sel_opb  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            sel_mode = bus.req_mode[i];
            sel_cin  = bus.req_cin[i];
            sel_cmd  = bus.req_cmd[i*M +: M];
            sel_opa  = bus.req_opa[i*N +: N];
            sel_opb  = bus.req_opb[i*N +: N];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   // Ready is gated by reset so no requester believes it was accepted while
   // the scheduler is being cleared.
   always_comb begin
      state_next  = state;
      req_ready_c = '0;
      take        = 1'b0;
      alu_ce      = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (any_req && !reset) begin
               take        = 1'b1;
               req_ready_c = grant;
               state_next  = S_ISSUE;
            end
         end
         S_ISSUE: begin
            alu_ce     = 1'b1;
            state_next = S_WAIT;
         end
         S_WAIT: begin
            if (cnt <= CNT_W'(1)) state_next = S_RESP;
         end
         S_RESP: begin
            if (bus.rsp_ready) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         op_mode    <= 1'b0;
         op_cin     <= 1'b0;
         op_cmd     <= '0;
         op_opa     <= '0;
         op_opb     <= '0;
         op_id      <= '0;
         cnt        <= '0;
         res_q      <= '0;
         flags_q    <= '0;
         last_grant <= ID_W'(N_REQ - 1);
      end else begin
         unique case (state)
            S_IDLE: begin
               if (take) begin
                  op_mode <= sel_mode;
                  op_cin  <= sel_cin;
                  op_cmd  <= sel_cmd;
                  op_opa  <= sel_opa;
                  op_opb  <= sel_opb;
                  op_id   <= grant_id;
               end
            end
            S_ISSUE: cnt <= lat_sel(op_mode, 32'(op_cmd), LAT, MUL_LAT);
            S_WAIT: begin
               cnt <= cnt - CNT_W'(1);
               // Last wait cycle: the ALU output now belongs to this op.
               if (cnt <= CNT_W'(1)) begin
                  res_q   <= alu_res;
                  flags_q <= flags_t'({alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e});
               end
            end
            S_RESP: begin
               if (bus.rsp_ready) last_grant <= op_id;
            end
            default: ;
         endcase
      end
   end

   // ALU fields come straight from the op register, so they hold through WAIT.
   assign alu_inp_valid = {2{alu_ce}};
   assign alu_mode      = op_mode;
   assign alu_cmd       = op_cmd;
   assign alu_opa       = op_opa;
   assign alu_opb       = op_opb;
   assign alu_cin       = op_cin;

   assign bus.req_ready = req_ready_c;
   assign bus.rsp_valid = (state == S_RESP);
   assign bus.rsp_id    = op_id;
   assign bus.rsp_res   = res_q;
   assign bus.rsp_flags = flags_q;
endmodule
